// File: rtl/smart_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smart_counter_pkg
// Description : Mode encodings shared by the multimode counter and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package smart_counter_pkg;

  localparam logic [1:0] c_WRAP    = 2'b00;
  localparam logic [1:0] c_SAT     = 2'b01;
  localparam logic [1:0] c_ONESHOT = 2'b10;

  // Encoding 2'b11 has no behaviour of its own and falls back to wrap.
  function automatic logic [1:0] resolve_mode(input logic [1:0] mode);
    return (mode == 2'b11) ? c_WRAP : mode;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : counter_prescaler
// Description : Divides enabled cycles; tick fires every prescale+1 of them.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             restart,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] r_cnt;
  logic             w_match;

  // Equality (not >=) so a prescale lowered mid-period lets the counter roll over.
  assign w_match = (r_cnt == prescale);
  assign tick    = enable && w_match && !restart;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (enable) begin
      if (w_match) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/multimode_counter.sv
`default_nettype none
// ============================================================================
// Module      : multimode_counter
// Description : Prescaled up/down counter with wrap, saturate and one-shot modes.
// Revision    : 1.0 - initial release
// ============================================================================
module multimode_counter
  import smart_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_down,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count_out,
  output logic             at_zero,
  output logic             at_limit,
  output logic             wrap_pulse,
  output logic             done
);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_done;
  logic             w_tick;
  logic             w_restart;
  logic             w_boundary;
  logic [1:0]       w_mode;
  logic [WIDTH-1:0] w_load_val;

  assign w_restart  = clear | load;
  assign w_mode     = resolve_mode(mode);
  assign w_load_val = (data_in > limit) ? limit : data_in;
  // Up uses >= so a limit lowered below the count still counts as the boundary.
  assign w_boundary = up_down ? (r_count >= limit) : (r_count == '0);

  counter_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .restart  (w_restart),
    .prescale (prescale),
    .tick     (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (clear) begin
        r_count <= '0;
        r_done  <= 1'b0;
      end else if (load) begin
        r_count <= w_load_val;
        r_done  <= 1'b0;
      end else if (w_tick && !r_done) begin
        if (!w_boundary) begin
          r_count <= up_down ? (r_count + 1'b1) : (r_count - 1'b1);
        end else begin
          case (w_mode)
            c_SAT:     r_count <= r_count;
            c_ONESHOT: r_done  <= 1'b1;
            default: begin
              r_count <= up_down ? '0 : limit;
              r_wrap  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign count_out  = r_count;
  assign wrap_pulse = r_wrap;
  assign done       = r_done;
  assign at_zero    = (r_count == '0);
  assign at_limit   = (r_count >= limit);

endmodule
`default_nettype wire

// File: tb/tb_multimode_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multimode_counter
// Description : Randomized scoreboard bench for multimode_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multimode_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0, clear = 1'b0, load = 1'b0, up_down = 1'b1;
  logic [7:0] data_in = '0, limit = '0;
  logic [1:0] mode = '0;
  logic [3:0] prescale = '0;
  logic [7:0] count_out;
  logic       at_zero, at_limit, wrap_pulse, done;

  multimode_counter #(.WIDTH(8), .PRE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .load(load),
    .data_in(data_in), .up_down(up_down), .mode(mode), .limit(limit),
    .prescale(prescale), .count_out(count_out), .at_zero(at_zero),
    .at_limit(at_limit), .wrap_pulse(wrap_pulse), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    int wrap;
    int dn;
    int z;
    int lim;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: count value, enabled cycles since last tick, done flag.
  int m_count = 0, m_pre = 0, m_done = 0;
  int cur_md = 0, cur_lim = 9, cur_ps = 0, cur_ud = 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus and predicts the state after the next rising edge.
  task automatic step(input bit en, input bit clr, input bit ld, input int d,
                      input bit ud, input int md, input int lim, input int ps);
    exp_t e;
    int wrap_ev;
    @(negedge clk);
    enable = en; clear = clr; load = ld; data_in = 8'(d);
    up_down = ud; mode = 2'(md); limit = 8'(lim); prescale = 4'(ps);
    wrap_ev = 0;
    if (clr) begin
      m_count = 0; m_pre = 0; m_done = 0;
    end else if (ld) begin
      m_count = (d < lim) ? d : lim; m_pre = 0; m_done = 0;
    end else if (en) begin
      if (m_pre == ps) begin
        m_pre = 0;
        if (m_done == 0) begin
          if (ud && m_count < lim) m_count = m_count + 1;
          else if (!ud && m_count > 0) m_count = m_count - 1;
          else if (md == 1) ;
          else if (md == 2) m_done = 1;
          else begin
            m_count = ud ? 0 : lim;
            wrap_ev = 1;
          end
        end
      end else begin
        m_pre = (m_pre + 1) % 16;
      end
    end
    e.count = m_count; e.wrap = wrap_ev; e.dn = m_done;
    e.z = (m_count == 0) ? 1 : 0; e.lim = (m_count >= lim) ? 1 : 0;
    sb.push_back(e);
  endtask

  // Monitor: every cycle with a pending prediction is compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count_out",  int'(count_out),  e.count);
        chk("wrap_pulse", int'(wrap_pulse), e.wrap);
        chk("done",       int'(done),       e.dn);
        chk("at_zero",    int'(at_zero),    e.z);
        chk("at_limit",   int'(at_limit),   e.lim);
      end
    end
  end

  initial begin
    #2;
    chk("reset count_out", int'(count_out), 0);
    chk("reset done", int'(done), 0);
    chk("reset wrap_pulse", int'(wrap_pulse), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Wrap up 0..9 then 0.
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 1, 0, 9, 0);
    // Saturate down from 3.
    step(0, 0, 1, 3, 0, 1, 9, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 9, 0);
    // One-shot up with prescale 2, then clear.
    step(0, 1, 0, 0, 1, 2, 4, 2);
    for (int i = 0; i < 25; i++) step(1, 0, 0, 0, 1, 2, 4, 2);
    step(1, 1, 0, 0, 1, 2, 4, 2);
    // Enable gating with prescale 3.
    step(1, 0, 0, 0, 1, 0, 50, 3);
    step(1, 0, 0, 0, 1, 0, 50, 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 50, 3);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 0, 50, 3);

    // Clear beats load; load clamps to limit.
    step(1, 1, 1, 8'h50, 1, 0, 100, 0);
    @(posedge clk); #2;
    chk("clear over load", int'(count_out), 0);
    step(0, 0, 1, 200, 1, 0, 100, 0);
    @(posedge clk); #2;
    chk("load clamp", int'(count_out), 100);

    // Async reset mid-run with count 0x37 and done set.
    step(0, 0, 1, 8'h37, 1, 2, 8'h37, 0);
    step(1, 0, 0, 0, 1, 2, 8'h37, 0);
    @(negedge clk);
    enable = 1'b0; load = 1'b0; clear = 1'b0;
    #1;
    chk("pre-reset count_out", int'(count_out), 8'h37);
    chk("pre-reset done", int'(done), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async reset count_out", int'(count_out), 0);
    chk("async reset done", int'(done), 0);
    #1 reset_n = 1'b1;
    m_count = 0; m_pre = 0; m_done = 0;

    // Randomized traffic with sticky configuration and frequent boundaries.
    for (int i = 0; i < 3000; i++) begin
      bit en, clr, ld;
      if ($urandom_range(0, 9) == 0) cur_md = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) cur_ud = $urandom_range(0, 1);
      if ($urandom_range(0, 14) == 0)
        cur_lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      if ($urandom_range(0, 14) == 0)
        cur_ps = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      en  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 49) == 0);
      ld  = ($urandom_range(0, 29) == 0);
      step(en, clr, ld, $urandom_range(0, 255), cur_ud, cur_md, cur_lim, cur_ps);
    end

    @(posedge clk); #3;
    chk("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multimode_counter.md
MULTIMODE_COUNTER -- requirements
Module: multimode_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter and data width in bits (min 2).
REQ-002 Parameter PRE_W, default 4: prescaler width in bits (min 1).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  counting permitted; the prescaler runs only while high.
REQ-006 clear  input  1  synchronous clear of count, done and prescaler.
REQ-007 load  input  1  synchronous load of data_in.
REQ-008 data_in  input  WIDTH  load value.
REQ-009 up_down  input  1  1 = count up, 0 = count down.
REQ-010 mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-011 limit  input  WIDTH  upper bound; the count range is 0..limit.
REQ-012 prescale  input  PRE_W  count advances once every prescale+1 enabled cycles.
REQ-013 count_out  output  WIDTH  current count (registered).
REQ-014 at_zero  output  1  combinational decode: count_out == 0.
REQ-015 at_limit  output  1  combinational decode: count_out >= limit.
REQ-016 wrap_pulse  output  1  registered one-cycle pulse on a wrap event.
REQ-017 done  output  1  registered sticky flag: one-shot run complete.

Function
REQ-018 Priority per rising edge is fixed: clear > load > tick.
REQ-019 Clear sets count = 0, done = 0, prescaler = 0 and wrap_pulse = 0 on the next edge.
REQ-020 Load sets count = min(data_in, limit), done = 0, prescaler = 0 and wrap_pulse = 0.
REQ-021 Tick occurs when enable = 1 and prescaler == prescale; otherwise, with enable = 1, the prescaler increments.
REQ-022 On a tick the prescaler returns to 0; with enable = 0 the prescaler and count hold.
REQ-023 Up boundary: the tick sees count >= limit; down boundary: the tick sees count == 0.
REQ-024 A non-boundary tick changes count by +1 (up) or -1 (down), with no overflow beyond WIDTH.
REQ-025 Wrap mode at boundary: up -> count = 0, down -> count = limit, and wrap_pulse = 1 for the following cycle only.
REQ-026 Saturate mode at boundary: count holds and no wrap_pulse is produced.
REQ-027 One-shot mode at boundary: count holds and done is set to 1.
REQ-028 While done = 1, ticks are ignored until clear or load.
REQ-029 A boundary tick in saturate or one-shot mode produces no wrap_pulse.
REQ-030 wrap_pulse is 0 in every cycle not immediately following a wrap event.
REQ-031 Changes to mode, up_down, limit and prescale take effect at the next tick, with no glitch on count_out.
REQ-032 If limit is lowered below count, the next up tick is a boundary tick; a down tick decrements normally.
REQ-033 A prescale change mid-period is compared against the current prescaler value on every cycle.

Reset
REQ-034 reset_n low immediately forces count_out = 0, prescaler = 0, wrap_pulse = 0 and done = 0, independent of clk.
REQ-035 reset_n deassertion is synchronised externally; the first tick is no earlier than prescale+1 enabled cycles after release.

Structure
REQ-036 Mode encodings (WRAP, SAT, ONESHOT) are localparams in shared package smart_counter_pkg.
REQ-037 The prescaler is a sub-module counter_prescaler (params PRE_W; ports clk, reset_n, enable, restart, prescale, tick).
REQ-038 There are no latches; all outputs except at_zero and at_limit come directly from flops.

Verification (WIDTH=8, PRE_W=4)
REQ-039 Wrap up: limit=9, prescale=0, mode=00, up, enable held from count 0 -> count_out 0..9, then 0; wrap_pulse high exactly one cycle, in the cycle after the 9->0 transition.
REQ-040 Saturate down: load 3, mode=01, down, prescale=0, 5 enabled cycles -> count_out 2,1,0,0,0; wrap_pulse never asserts.
REQ-041 One-shot with prescale: limit=4, prescale=2, mode=10, up from 0 -> count steps every 3 cycles to 4 and done=1; 10 further enabled cycles leave count=4; clear -> count=0, done=0.
REQ-042 Priority and clamp: clear and load asserted together with data_in=0x50 -> count=0; load data_in=200 with limit=100 -> count=100.
REQ-043 Async reset mid-run: count=0x37, done=1, reset_n pulsed low between edges -> count_out=0 and done=0 before the next clk edge.
REQ-044 Enable gating: prescale=3, enable dropped after 2 enabled cycles for 5 cycles, then raised -> tick occurs after exactly 2 more enabled cycles.
